updn_counter: RTL and testbench
===============================

UPDN_COUNTER -- requirements
Module: updn_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: terminal value; count range is 0..MAX_VAL.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rb, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up_dn, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-009 SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-010 SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 SHALL have port count, output, WIDTH bits: registered count.
REQ-012 SHALL have port tc, output, 1 bit: terminal count; combinational from count and up_dn.
REQ-013 SHALL have port wrap, output, 1 bit: registered one-cycle pulse when the count wrapped or saturated.

Function
REQ-014 SHALL resolve a cycle by priority: clr > load > en > hold.
REQ-015 SHALL, on clr=1, set count to 0 next edge, regardless of load, en or up_dn.
REQ-016 SHALL, on load=1 and clr=0, set count to min(load_val, MAX_VAL) next edge.
REQ-017 SHALL, on en=1, up_dn=1, count<MAX_VAL, set count to count+1 next edge.
REQ-018 SHALL, on en=1, up_dn=0, count>0, set count to count-1 next edge.
REQ-019 SHALL, when up-count is requested at MAX_VAL, load 0 if SATURATE=0 and hold MAX_VAL if SATURATE=1.
REQ-020 SHALL, when down-count is requested at 0, load MAX_VAL if SATURATE=0 and hold 0 if SATURATE=1.
REQ-021 SHALL register wrap=1 for exactly the cycle after a REQ-019/REQ-020 event, in both modes, and 0 otherwise, including on clr and load cycles.
REQ-022 SHALL drive tc=1 when (up_dn=1 and count==MAX_VAL) or (up_dn=0 and count==0), independent of en.
REQ-023 SHALL hold count and clear wrap when en=load=clr=0.
REQ-024 SHALL compute all arithmetic without the intermediate result overflowing WIDTH; count never exceeds MAX_VAL.
REQ-025 SHALL change direction with no bubble: an up_dn toggle takes effect in the same cycle.

Reset
REQ-026 SHALL, while rb=0, force count=0 and wrap=0 asynchronously; tc follows REQ-022 (1 if up_dn=0).
REQ-027 SHALL, when rb is asserted mid-count, abandon any pending load or wrap; the first edge after deassertion applies REQ-014 normally.

Structure
REQ-028 SHALL place the direction encodings (UP=1, DOWN=0) and the mode constants (WRAP=0, SAT=1) in shared package counter_pkg.
REQ-029 SHALL implement next-value arithmetic, bound detection and the clamp in one combinational sub-module, updn_counter_next; all state stays in updn_counter.
REQ-030 SHALL keep count and wrap as the only state, with no latches or derived clocks.

Verification
REQ-031 SHALL cover wrap-up: WIDTH=8, SATURATE=0, load 0xFE, then en=1 up for 3 cycles -> count FE,FF,00,01; wrap=1 only in the cycle count shows 00; tc=1 at FF.
REQ-032 SHALL cover saturate-down: SATURATE=1, count=1, en=1 down for 3 cycles -> count 0,0,0; wrap=1 on the 2nd and 3rd cycles; tc=1 throughout at 0.
REQ-033 SHALL cover priority: clr=1, load=1, load_val=0x55, en=1 in the same cycle -> count 0; then load=1 with en=1 -> count 0x55.
REQ-034 SHALL cover the modulo bound: MAX_VAL=9, load_val=12 -> count 9; then up with wrap -> 0 with wrap=1; then down -> 9 with wrap=1.
REQ-035 SHALL cover async reset: assert rb=0 between edges while count=0x80 -> count 0 immediately, with no clk edge; after release and en=1 up -> count 1.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: direction and bound-mode encodings shared by the up/down counter.
package counter_pkg;
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;
  localparam int   WRAP = 0;
  localparam int   SAT  = 1;
endpackage

// File: rtl/updn_counter_if.sv
// updn_counter_if: control and status bundle for one up/down counter instance.
interface updn_counter_if #(parameter int WIDTH = 8) (input logic clk);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  modport master (input clk, count, tc, wrap, output en, up_dn, clr, load, load_val);
  modport slave  (input clk, en, up_dn, clr, load, load_val, output count, tc, wrap);
endinterface

// File: rtl/updn_counter_next.sv
// updn_counter_next: next count, bound detection and clamp; purely combinational.
module updn_counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_d,
  output logic             wrap_d,
  output logic             tc
);
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] lv_clamp;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  // the +1/-1 paths are only taken strictly inside the range, so they never overflow
  always_comb begin
    at_max   = count == MAX_VAL;
    at_min   = count == '0;
    tc       = (up_dn == UP) ? at_max : at_min;
    lv_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    up_val   = at_max ? ((SATURATE == SAT) ? MAX_VAL : '0) : count + 1'b1;
    dn_val   = at_min ? ((SATURATE == SAT) ? '0 : MAX_VAL) : count - 1'b1;
    count_d  = clr ? '0 : load ? lv_clamp : !en ? count : (up_dn == UP) ? up_val : dn_val;
    wrap_d   = !clr && !load && en && tc;
  end
endmodule

// File: rtl/updn_counter.sv
// updn_counter: parameterised up/down counter with clear, load, wrap or saturate at bounds.
module updn_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             rb,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic             wrap_d;
  logic             wrap_q;
  updn_counter_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SATURATE(SATURATE)) u_next (
    .count(count_q), .en(en), .up_dn(up_dn), .clr(clr), .load(load), .load_val(load_val),
    .count_d(count_d), .wrap_d(wrap_d), .tc(tc)
  );
  always_ff @(posedge clk or negedge rb) begin
    if (!rb) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end
  assign count = count_q;
  assign wrap  = wrap_q;
endmodule

// File: tb/tb_updn_counter.sv
// tb_updn_counter: three counter configurations driven in lockstep against an arithmetic model.
module tb_updn_counter;
  import counter_pkg::*;
  logic clk = 1'b0;
  logic rb  = 1'b0;
  always #5 clk = ~clk;
  logic       en = 0, up = 0, cl = 0, ld = 0;
  logic [7:0] lv = 0;
  updn_counter_if #(8) i0 (clk);
  updn_counter_if #(8) i1 (clk);
  updn_counter_if #(4) i2 (clk);
  assign {i0.en, i0.up_dn, i0.clr, i0.load, i0.load_val} = {en, up, cl, ld, lv};
  assign {i1.en, i1.up_dn, i1.clr, i1.load, i1.load_val} = {en, up, cl, ld, lv};
  assign {i2.en, i2.up_dn, i2.clr, i2.load, i2.load_val} = {en, up, cl, ld, lv[3:0]};
  updn_counter #(.WIDTH(8), .SATURATE(WRAP)) d0 (
    .clk(clk), .rb(rb), .en(i0.en), .up_dn(i0.up_dn), .clr(i0.clr), .load(i0.load),
    .load_val(i0.load_val), .count(i0.count), .tc(i0.tc), .wrap(i0.wrap));
  updn_counter #(.WIDTH(8), .SATURATE(SAT)) d1 (
    .clk(clk), .rb(rb), .en(i1.en), .up_dn(i1.up_dn), .clr(i1.clr), .load(i1.load),
    .load_val(i1.load_val), .count(i1.count), .tc(i1.tc), .wrap(i1.wrap));
  updn_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(WRAP)) d2 (
    .clk(clk), .rb(rb), .en(i2.en), .up_dn(i2.up_dn), .clr(i2.clr), .load(i2.load),
    .load_val(i2.load_val), .count(i2.count), .tc(i2.tc), .wrap(i2.wrap));
  int n_chk = 0;
  int n_fail = 0;
  int mc[3] = '{0, 0, 0};
  int mw[3] = '{0, 0, 0};
  int mx[3] = '{255, 255, 9};
  int ms[3] = '{0, 1, 0};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int mtc(input int k);
    return up ? int'(mc[k] == mx[k]) : int'(mc[k] == 0);
  endfunction
  task automatic check_all(input string tag);
    chk({tag, " d0.count"}, 32'(i0.count), mc[0]);
    chk({tag, " d0.wrap"},  32'(i0.wrap),  mw[0]);
    chk({tag, " d0.tc"},    32'(i0.tc),    mtc(0));
    chk({tag, " d1.count"}, 32'(i1.count), mc[1]);
    chk({tag, " d1.wrap"},  32'(i1.wrap),  mw[1]);
    chk({tag, " d1.tc"},    32'(i1.tc),    mtc(1));
    chk({tag, " d2.count"}, 32'(i2.count), mc[2]);
    chk({tag, " d2.wrap"},  32'(i2.wrap),  mw[2]);
    chk({tag, " d2.tc"},    32'(i2.tc),    mtc(2));
  endtask
  task automatic step(input string tag);
    int nc[3];
    int nw[3];
    for (int k = 0; k < 3; k++) begin
      int v;
      v = (k == 2) ? int'(lv[3:0]) : int'(lv);
      nw[k] = 0;
      if (cl) nc[k] = 0;
      else if (ld) nc[k] = (v > mx[k]) ? mx[k] : v;
      else if (en) begin
        nc[k] = up ? mc[k] + 1 : mc[k] - 1;
        if (nc[k] < 0 || nc[k] > mx[k]) begin
          nw[k] = 1;
          nc[k] = ms[k] ? mc[k] : (up ? 0 : mx[k]);
        end
      end else nc[k] = mc[k];
    end
    @(posedge clk);
    #1;
    mc = nc;
    mw = nw;
    check_all(tag);
  endtask
  initial begin
    #12;
    check_all("reset");
    @(negedge clk);
    rb = 1'b1;
    ld = 1; lv = 8'hFE;
    step("load_fe");
    chk("wrapup fe", 32'(i0.count), 32'hFE);
    ld = 0; en = 1; up = 1;
    step("wrapup1");
    chk("wrapup ff", 32'(i0.count), 32'hFF);
    chk("wrapup tc", 32'(i0.tc), 1);
    step("wrapup2");
    chk("wrapup 00", 32'(i0.count), 0);
    chk("wrapup pulse", 32'(i0.wrap), 1);
    step("wrapup3");
    chk("wrapup 01", 32'(i0.count), 1);
    chk("wrapup nopulse", 32'(i0.wrap), 0);
    ld = 1; lv = 8'h01; en = 0;
    step("load_1");
    ld = 0; en = 1; up = 0;
    step("satdn1");
    chk("satdn w1", 32'(i1.wrap), 0);
    step("satdn2");
    chk("satdn w2", 32'(i1.wrap), 1);
    step("satdn3");
    chk("satdn c3", 32'(i1.count), 0);
    chk("satdn w3", 32'(i1.wrap), 1);
    chk("satdn tc", 32'(i1.tc), 1);
    cl = 1; ld = 1; lv = 8'h55; up = 1;
    step("prio_clr");
    chk("prio clr", 32'(i0.count), 0);
    cl = 0;
    step("prio_load");
    chk("prio load", 32'(i0.count), 32'h55);
    lv = 8'd12;
    step("mod_load");
    chk("mod clamp", 32'(i2.count), 9);
    ld = 0;
    step("mod_up");
    chk("mod up", 32'(i2.count), 0);
    chk("mod up wrap", 32'(i2.wrap), 1);
    up = 0;
    step("mod_dn");
    chk("mod dn", 32'(i2.count), 9);
    chk("mod dn wrap", 32'(i2.wrap), 1);
    ld = 1; lv = 8'h80; en = 0;
    step("load_80");
    #3;
    rb = 1'b0;
    #1;
    mc = '{0, 0, 0};
    mw = '{0, 0, 0};
    check_all("async_rst");
    chk("async cnt", 32'(i0.count), 0);
    @(negedge clk);
    rb = 1'b1;
    ld = 0; en = 1; up = 1;
    step("post_rst");
    chk("post rst cnt", 32'(i0.count), 1);
    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      cl = 1'($urandom_range(0, 19) == 0);
      ld = 1'($urandom_range(0, 9) == 0);
      lv = 8'($urandom);
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
